// File: rtl/cdma_despreader.sv
// Despreader for the 31-chip Gold-coded chip stream: regenerates the code from seed_i,
// correlates one code period per data bit, acquires phase by slipping and tracks lock.
module cdma_despreader #(
  parameter logic [23:0] CHIP_DIV = 24'd10_000_000,
  parameter logic [4:0]  THRESH   = 5'd27
) (
  input  logic       clk_i,
  input  logic       set_i,
  input  logic       chip_i,
  input  logic [3:0] seed_i,
  output logic       bit_o,
  output logic       bit_valid_o,
  output logic       lock_o,
  output logic [4:0] corr_o
);

  typedef enum logic {ST_ACQ = 1'b0, ST_TRACK = 1'b1} state_t;

  logic [23:0] div_q, div_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  acc_q, acc_d;
  logic        miss_q, miss_d;
  logic        slip_q, slip_d;
  logic [4:0]  a_q, a_d;
  logic [4:0]  b_q, b_d;
  logic [3:0]  seed_q, seed_d;
  state_t      state_q, state_d;
  logic        bit_q, bit_d;
  logic        valid_q, valid_d;
  logic [4:0]  corr_q, corr_d;

  logic        strobe;
  logic        gold;
  logic [4:0]  cnt;
  logic        dec_zero;
  logic        dec_one;

  always_comb begin
    div_d   = div_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    miss_d  = miss_q;
    slip_d  = slip_q;
    a_d     = a_q;
    b_d     = b_q;
    seed_d  = seed_i;
    state_d = state_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    corr_d  = corr_q;

    strobe   = (div_q == (CHIP_DIV - 24'd1));
    gold     = a_q[0] ^ b_q[0];
    cnt      = acc_q + {4'b0000, (chip_i == gold)};
    dec_zero = (cnt >= THRESH);
    dec_one  = (cnt <= (5'd31 - THRESH));

    div_d = strobe ? 24'd0 : div_q + 24'd1;

    // A new seed restarts acquisition and discards any epoch ending this cycle
    if (seed_i != seed_q) begin
      a_d     = 5'b00001;
      b_d     = {1'b1, seed_i};
      idx_d   = 5'd0;
      acc_d   = 5'd0;
      miss_d  = 1'b0;
      slip_d  = 1'b0;
      state_d = ST_ACQ;
    end else if (strobe) begin
      if (slip_q) begin
        slip_d = 1'b0;
      end else begin
        a_d = {a_q[0] ^ a_q[2], a_q[4:1]};
        b_d = {b_q[0] ^ b_q[2] ^ b_q[3] ^ b_q[4], b_q[4:1]};
      end

      if (idx_q == 5'd30) begin
        idx_d  = 5'd0;
        acc_d  = 5'd0;
        corr_d = cnt;
        if (dec_zero || dec_one) begin
          bit_d   = dec_one;
          valid_d = 1'b1;
          state_d = ST_TRACK;
          miss_d  = 1'b0;
        end else if (state_q == ST_ACQ) begin
          slip_d = 1'b1;
        end else if (miss_q) begin
          state_d = ST_ACQ;
          miss_d  = 1'b0;
        end else begin
          miss_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + 5'd1;
        acc_d = cnt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge set_i) begin
    if (!set_i) begin
      div_q   <= 24'd0;
      idx_q   <= 5'd0;
      acc_q   <= 5'd0;
      miss_q  <= 1'b0;
      slip_q  <= 1'b0;
      a_q     <= 5'b00001;
      b_q     <= {1'b1, seed_i};
      seed_q  <= seed_i;
      state_q <= ST_ACQ;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      corr_q  <= 5'd0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      miss_q  <= miss_d;
      slip_q  <= slip_d;
      a_q     <= a_d;
      b_q     <= b_d;
      seed_q  <= seed_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      corr_q  <= corr_d;
    end
  end

  assign bit_o       = bit_q;
  assign bit_valid_o = valid_q;
  assign lock_o      = (state_q == ST_TRACK);
  assign corr_o      = corr_q;

endmodule

// File: tb/tb_cdma_despreader.sv
// Bench for cdma_despreader: a transmitter model drives chips and a table-based
// behavioural model of the receiver predicts every output cycle by cycle.
module tb_cdma_despreader;

  localparam int DIV = 2;
  localparam int TH  = 27;

  logic       clk_i  = 1'b0;
  logic       set_i  = 1'b1;
  logic       chip_i = 1'b0;
  logic [3:0] seed_i = 4'b1010;
  logic       bit_o;
  logic       bit_valid_o;
  logic       lock_o;
  logic [4:0] corr_o;

  int n_checks = 0;
  int n_errors = 0;

  // Receiver reference model state
  int          m_div, m_idx, m_acc, m_ph, m_miss, m_corr;
  bit          m_slip, m_lock, m_bit, m_valid, m_taken;
  logic [3:0]  m_seed;
  logic [30:0] m_gold;

  // Transmitter model state
  logic [30:0] tx_gold;
  int          tx_ph, tx_cnt, tx_flips, tx_next_flips, tx_base;
  bit          tx_data, tx_next_data, tx_prev_data, tx_rand;

  cdma_despreader #(.CHIP_DIV(24'd2), .THRESH(5'd27)) dut (
    .clk_i      (clk_i),
    .set_i      (set_i),
    .chip_i     (chip_i),
    .seed_i     (seed_i),
    .bit_o      (bit_o),
    .bit_valid_o(bit_valid_o),
    .lock_o     (lock_o),
    .corr_o     (corr_o)
  );

  always #5 clk_i = ~clk_i;

  // Gold sequence from the two linear recurrences over one full period
  function automatic logic [30:0] gold_seq(input logic [3:0] seed);
    bit sa[36];
    bit sb[36];
    logic [4:0]  b0;
    logic [30:0] g;
    b0 = {1'b1, seed};
    for (int i = 0; i < 5; i++) begin
      sa[i] = (i == 0);
      sb[i] = b0[i];
    end
    for (int n = 0; n < 31; n++) begin
      sa[n+5] = sa[n+2] ^ sa[n];
      sb[n+5] = sb[n+4] ^ sb[n+3] ^ sb[n+2] ^ sb[n];
    end
    for (int n = 0; n < 31; n++) g[n] = sa[n] ^ sb[n];
    return g;
  endfunction

  function automatic bit is_flip(input int c);
    for (int k = 0; k < tx_flips; k++)
      if (c == (tx_base + 6 * k) % 31) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_idx = 0; m_acc = 0; m_ph = 0; m_miss = 0; m_corr = 0;
    m_slip = 0; m_lock = 0; m_bit = 0; m_valid = 0; m_taken = 0;
    m_seed = seed_i;
    m_gold = gold_seq(seed_i);
  endtask

  task automatic model_step();
    bit strobe;
    int cnt;
    strobe  = (m_div == DIV - 1);
    m_div   = strobe ? 0 : m_div + 1;
    m_valid = 0;
    m_taken = 0;
    if (seed_i != m_seed) begin
      m_seed = seed_i;
      m_gold = gold_seq(seed_i);
      m_ph = 0; m_idx = 0; m_acc = 0; m_miss = 0; m_lock = 0; m_slip = 0;
    end else if (strobe) begin
      m_taken = 1;
      cnt = m_acc + ((chip_i == m_gold[m_ph]) ? 1 : 0);
      if (m_slip) m_slip = 0;
      else m_ph = (m_ph + 1) % 31;
      if (m_idx == 30) begin
        m_idx = 0; m_acc = 0; m_corr = cnt;
        if (cnt >= TH || cnt <= 31 - TH) begin
          m_bit = (cnt <= 31 - TH); m_valid = 1; m_lock = 1; m_miss = 0;
        end else if (!m_lock) begin
          m_slip = 1;
        end else if (m_miss == 1) begin
          m_lock = 0; m_miss = 0;
        end else begin
          m_miss = 1;
        end
      end else begin
        m_idx++;
        m_acc = cnt;
      end
    end
  endtask

  task automatic tx_start(input logic [3:0] seed, input int offset);
    tx_gold  = gold_seq(seed);
    tx_ph    = offset;
    tx_cnt   = 0;
    tx_data  = tx_next_data;
    tx_flips = tx_next_flips;
    tx_base  = $urandom_range(0, 30);
  endtask

  task automatic tx_advance();
    tx_ph = (tx_ph + 1) % 31;
    tx_cnt++;
    if (tx_cnt == 31) begin
      tx_cnt       = 0;
      tx_prev_data = tx_data;
      tx_data      = tx_rand ? bit'($urandom_range(0, 1)) : tx_next_data;
      tx_flips     = tx_next_flips;
      tx_base      = $urandom_range(0, 30);
    end
  endtask

  task automatic applyStimulus();
    chip_i = tx_gold[tx_ph] ^ tx_data ^ is_flip(tx_cnt);
    @(posedge clk_i);
    model_step();
    #1;
    checkOutput("bit_o", bit_o, m_bit);
    checkOutput("bit_valid_o", bit_valid_o, m_valid);
    checkOutput("lock_o", lock_o, m_lock);
    checkOutput("corr_o", corr_o, m_corr);
    if (m_taken) tx_advance();
  endtask

  task automatic doReset(input int offset);
    set_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    set_i = 1'b1;
    model_reset();
    tx_start(seed_i, offset);
  endtask

  task automatic waitPulse(input string tag, input int max_cycles);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!bit_valid_o && n < max_cycles);
    checkOutput({tag, "_pulse_seen"}, bit_valid_o, 1);
  endtask

  task automatic waitLock(input string tag);
    int n;
    n = 0;
    while (!lock_o && n < 31 * 31 * DIV + 200) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_lock_within_31_epochs"}, lock_o, 1);
  endtask

  initial begin
    int n;
    tx_next_data = 0; tx_next_flips = 0; tx_rand = 0; tx_prev_data = 0;
    tx_gold = '0; tx_ph = 0; tx_cnt = 0; tx_flips = 0; tx_base = 0; tx_data = 0;

    $display("[TB] reset state");
    #1 set_i = 1'b0;
    #2;
    checkOutput("reset_bit", bit_o, 0);
    checkOutput("reset_valid", bit_valid_o, 0);
    checkOutput("reset_lock", lock_o, 0);
    checkOutput("reset_corr", corr_o, 0);

    $display("[TB] aligned data 0 then data 1");
    doReset(0);
    tx_next_data = 1;
    waitPulse("t1", 80);
    checkOutput("t1_corr", corr_o, 31);
    checkOutput("t1_bit", bit_o, 0);
    checkOutput("t1_lock", lock_o, 1);
    for (int e = 0; e < 2; e++) begin
      waitPulse("t2", 80);
      checkOutput("t2_corr", corr_o, 0);
      checkOutput("t2_bit", bit_o, 1);
      checkOutput("t2_lock", lock_o, 1);
    end
    tx_rand = 1;
    for (int e = 0; e < 4; e++) begin
      waitPulse("rand", 80);
      checkOutput("rand_corr", corr_o, tx_prev_data ? 0 : 31);
      checkOutput("rand_bit", bit_o, tx_prev_data);
    end

    $display("[TB] acquisition from 5-chip offset");
    tx_rand = 0; tx_next_data = 0;
    doReset(5);
    waitLock("t3");
    checkOutput("t3_corr_at_lock", (corr_o == 0 || corr_o == 31), 1);
    waitPulse("t3_track", 80);
    checkOutput("t3_corr_track", corr_o, 31);

    $display("[TB] chip errors while locked");
    tx_next_flips = 4;
    waitPulse("t4_clean", 80);
    waitPulse("t4_flip4", 80);
    checkOutput("t4_corr27", corr_o, 27);
    checkOutput("t4_bit", bit_o, 0);
    tx_next_flips = 5;
    waitPulse("t4_flip4b", 80);
    checkOutput("t4_corr27b", corr_o, 27);
    repeat (31 * DIV) applyStimulus();
    checkOutput("t4_miss1_corr", corr_o, 26);
    checkOutput("t4_miss1_lock", lock_o, 1);
    tx_next_flips = 0;
    repeat (31 * DIV) applyStimulus();
    checkOutput("t4_miss2_corr", corr_o, 26);
    checkOutput("t4_miss2_lock", lock_o, 0);
    waitLock("t4_relock");

    $display("[TB] seed change mid-epoch and at epoch end");
    repeat (9) applyStimulus();
    seed_i = 4'b0011;
    tx_start(4'b0011, 0);
    applyStimulus();
    checkOutput("t5_lock_drop", lock_o, 0);
    checkOutput("t5_corr_hold", corr_o, 31);
    waitPulse("t5_relock", 80);
    checkOutput("t5_corr", corr_o, 31);
    checkOutput("t5_lock", lock_o, 1);
    n = 0;
    while (!(m_idx == 30 && m_div == DIV - 1) && n < 100) begin
      applyStimulus();
      n++;
    end
    seed_i = 4'b1010;
    tx_start(4'b1010, 0);
    applyStimulus();
    checkOutput("t5b_no_pulse", bit_valid_o, 0);
    checkOutput("t5b_lock_drop", lock_o, 0);
    waitPulse("t5b_relock", 80);
    checkOutput("t5b_corr", corr_o, 31);

    $display("[TB] asynchronous reset mid-epoch");
    repeat (15) applyStimulus();
    checkOutput("t6_pre_lock", lock_o, 1);
    #2 set_i = 1'b0;
    #1;
    checkOutput("t6_async_bit", bit_o, 0);
    checkOutput("t6_async_valid", bit_valid_o, 0);
    checkOutput("t6_async_lock", lock_o, 0);
    checkOutput("t6_async_corr", corr_o, 0);
    doReset(0);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!bit_valid_o && n < 200);
    checkOutput("t6_first_pulse_cycles", n, 31 * DIV);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
